tt_um_emern_spi_byte_rx: RTL
============================

// Module: tt_um_emern_spi_byte_rx
// PURPOSE
// - SPI target receive front stage, upstream of the command decoder (register/polygon loader).
// - Synchronises the raw pin inputs cs/sck/mosi into clk and deserialises SPI mode-0, MSB-first bytes.
// - Buffers received bytes in a small FIFO with a valid/ready handshake to the decoder; drives MISO with a status byte.
// PARAMETERS
// - SYNC_STAGES  2  flops per pin synchroniser (legal values 2..3)
// - FIFO_DEPTH   4  byte FIFO entries (power of two, 2..8)
// PORTS
// - clk          in   1  system clock; one clock domain; clk freq >= 4x sck freq
// - rst          in   1  synchronous, active-high reset
// - cs_in        in   1  SPI chip select pin, active low, asynchronous to clk
// - sck_in       in   1  SPI clock pin, asynchronous to clk
// - mosi_in      in   1  SPI data in pin, asynchronous to clk
// - miso_out     out  1  SPI data out (status byte)
// - byte_data    out  8  FIFO head byte
// - byte_first   out  1  head byte is the first byte of its frame
// - byte_valid   out  1  FIFO non-empty
// - byte_ready   in   1  decoder accepts head byte when byte_valid & byte_ready
// - frame_done   out  1  1-cycle pulse on synchronised cs rising edge
// - frame_partial out 1  1-cycle pulse with frame_done when bit count at cs rise != 0
// - overflow     out  1  sticky: byte arrived while FIFO full
// - ovf_clr      in   1  1-cycle clear of overflow
// BEHAVIOUR
// - Reset: all sync flops to idle (cs=1, sck=0, mosi=0); miso_out=0, byte_data=0, byte_first=0, byte_valid=0,
//   frame_done=0, frame_partial=0, overflow=0; FIFO empty; bit counter 0; frame inactive.
// - Edge detect on last sync stage vs. one extra history flop. Pin change sampled at clk edge k -> strobe at k+SYNC_STAGES.
// - cs falling strobe: frame active, bit count=0, first_pending=1, MISO shift reg loads STATUS,
//   miso_out = STATUS[7] same cycle. STATUS = {overflow, fifo_full, fifo_empty, 1'b0, frame_count[3:0]}.
// - frame_count: 4-bit, increments on every frame_done, wraps 15->0; reset 0.
// - sck rising strobe while frame active: shift in mosi (MSB first), bit count +1 (3-bit, wraps 7->0).
// - sck falling strobe while frame active: MISO shift reg shifts left, miso_out = next bit; after 8 bits shifts in 0.
// - Byte complete (8th rising strobe): push {first_pending, byte} same cycle; first_pending cleared.
//   byte_valid visible next cycle if FIFO was empty (pin-to-valid = SYNC_STAGES+1 clk after sampled sck edge).
// - FIFO full on push: byte dropped, overflow set next cycle; first_pending still cleared.
// - Push and pop same cycle: both happen; at full the pop frees the slot so push is accepted (no overflow).
// - Pop (valid & ready): head advances next cycle; byte_data/byte_first stable while valid & !ready.
// - ovf_clr and new overflow same cycle: overflow ends set (set wins).
// - sck/mosi strobes ignored while cs inactive (sync cs high); partial byte discarded on cs rise, not pushed.
// - cs rising strobe: frame_done=1 for 1 cycle; frame_partial=1 same cycle iff bit count != 0; bit count->0;
//   miso_out->0. FIFO contents are kept across frames.
// - cs falling and rising with no sck edges: frame_done pulse, no bytes, frame_partial=0.
// - rst mid-frame: everything returns to reset state next cycle; a frame in progress is abandoned and the
//   next byte push requires a fresh cs falling edge.
// - Pointers: log2(FIFO_DEPTH)+1 bits, full when MSBs differ and low bits equal; wrap naturally.
// TESTING
// - Frame of 0xA5 with clk=8x sck -> one push, byte_data=0xA5, byte_first=1, byte_valid 3 clk after 8th sck rise; frame_done=1, frame_partial=0.
// - 3-byte frame 0x01,0x02,0x03, byte_ready=1 -> bytes in order, byte_first=1,0,0; second frame 0x7E -> byte_first=1.
// - byte_ready=0, frame of 5 bytes at FIFO_DEPTH=4 -> 4 bytes held, overflow=1 after 5th; ovf_clr -> overflow=0; drain yields first 4 bytes.
// - FIFO full, pop and 8th sck edge in same cycle -> push accepted, overflow stays 0, count remains 4.
// - Frame of 12 bits (0xC3 + 4 bits) -> one push 0xC3, frame_done with frame_partial=1, no second byte.
// - After 2 frames, overflow=0, FIFO empty, new frame -> MISO bits on falling edges read 0b0010_0010 (0x22).

Source files
------------

// File: rtl/tt_um_emern_spi_byte_rx.sv
// SPI mode-0 target receive front end: pin synchronisers, MSB-first byte
// deserialiser, byte FIFO toward the command decoder, status byte on MISO.

module tt_um_emern_spi_byte_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_in,
    input  logic       sck_in,
    input  logic       mosi_in,
    output logic       miso_out,
    output logic [7:0] byte_data,
    output logic       byte_first,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_done,
    output logic       frame_partial,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_FRAME
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_hist;
    logic                   sck_hist;
    logic [SYNC_STAGES:0]   primed;

    logic cs_s;
    logic sck_s;
    logic mosi_s;
    logic active;
    logic cs_fall;
    logic cs_rise;
    logic sck_rise;
    logic sck_fall;

    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;
    logic       first_pending;
    logic [7:0] miso_sh;
    logic [3:0] frame_count;
    logic [7:0] status;

    logic       push_req;
    logic [7:0] push_data;
    logic       pop;
    logic       accept;

    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic [8:0]  head;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_hist   <= 1'b1;
            sck_hist  <= 1'b0;
            primed    <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_in};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            cs_hist   <= cs_sync[SYNC_STAGES-1];
            sck_hist  <= sck_sync[SYNC_STAGES-1];
            primed    <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign active = (state == ST_FRAME);

    // Edges count only once the chain holds real pin samples, so a cs
    // held low through reset does not look like a fresh falling edge.
    assign cs_fall  = primed[SYNC_STAGES] & cs_hist & ~cs_s;
    assign cs_rise  = primed[SYNC_STAGES] & ~cs_hist & cs_s;
    assign sck_rise = active & ~cs_s & ~sck_hist & sck_s;
    assign sck_fall = active & ~cs_s & sck_hist & ~sck_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (cs_fall) state_next = ST_FRAME;
            ST_FRAME: if (cs_rise) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign status    = {overflow, fifo_full, fifo_empty, 1'b0, frame_count};
    assign push_req  = sck_rise & (bit_cnt == 3'd7);
    assign push_data = {rx_sh, mosi_s};
    assign miso_out  = miso_sh[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= '0;
            rx_sh         <= '0;
            first_pending <= 1'b0;
            miso_sh       <= '0;
            frame_done    <= 1'b0;
            frame_partial <= 1'b0;
            frame_count   <= '0;
        end else begin
            frame_done    <= cs_rise;
            frame_partial <= cs_rise & (bit_cnt != 3'd0);
            if (cs_rise) frame_count <= frame_count + 4'd1;
            if (cs_fall) begin
                bit_cnt       <= '0;
                first_pending <= 1'b1;
                miso_sh       <= status;
            end else if (cs_rise) begin
                bit_cnt <= '0;
                miso_sh <= '0;
            end else begin
                if (sck_rise) begin
                    rx_sh   <= {rx_sh[5:0], mosi_s};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) first_pending <= 1'b0;
                end
                if (sck_fall) miso_sh <= {miso_sh[6:0], 1'b0};
            end
        end
    end

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) &&
                        (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop        = byte_valid & byte_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign accept     = push_req & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (accept) mem[wptr[AW-1:0]] <= {first_pending, push_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            if (push_req & fifo_full & ~pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head       = mem[rptr[AW-1:0]];
    assign byte_valid = ~fifo_empty;
    assign byte_data  = fifo_empty ? 8'h00 : head[7:0];
    assign byte_first = fifo_empty ? 1'b0 : head[8];

endmodule
